// File: rtl/glove_centroid_pkg.sv
// Shared widths, FSM encoding and latency constant for the glove centroid block.
package glove_centroid_pkg;

  localparam int X_W   = 10;  // pixel column width (640-wide frame)
  localparam int Y_W   = 10;  // pixel row width (480-tall frame)
  localparam int CNT_W = 19;  // per-glove pixel count, holds 640*480
  localparam int SUM_W = 28;  // per-glove coordinate sum, holds 639*307200

  // Narrowest quotient that still covers both x and y centroids.
  localparam int Q_W = (X_W > Y_W) ? X_W : Y_W;

  // Accepted frame_end to coords_valid: four divisions of (1 start + SUM_W wait)
  // cycles each, plus the DONE cycle.
  localparam int CENTROID_LATENCY = 4 * (SUM_W + 1) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DIV_G1X = 3'd1,
    ST_DIV_G1Y = 3'd2,
    ST_DIV_G2X = 3'd3,
    ST_DIV_G2Y = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/glove_centroid_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin (restarts if already running)
//   dividend   : DIVIDEND_W-bit numerator
//   divisor    : DIVISOR_W-bit denominator (caller guarantees non-zero)
//   quotient   : low QUOT_W bits of the quotient, valid while done is high
//   done       : one-cycle pulse DIVIDEND_W cycles after start
module seq_divider #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 19,
  parameter int QUOT_W     = DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  done_q;

  logic [DIVIDEND_W-1:0] in_quo;
  logic [DIVISOR_W-1:0]  in_rem;
  logic [DIVISOR_W-1:0]  in_dvs;
  logic [DIVISOR_W:0]    rem_sh;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_d;
  logic [DIVIDEND_W-1:0] quo_d;

  // The first iteration is folded into the start cycle so that the final
  // quotient bit lands exactly DIVIDEND_W cycles after start.
  always_comb begin
    in_quo = start ? dividend : quo_q;
    in_rem = start ? '0       : rem_q;
    in_dvs = start ? divisor  : dvs_q;
    rem_sh = {in_rem, in_quo[DIVIDEND_W-1]};
    ge     = (rem_sh >= {1'b0, in_dvs});
    // When ge, the true difference is < divisor, so the low bits are exact.
    rem_d  = ge ? (rem_sh[DIVISOR_W-1:0] - in_dvs) : rem_sh[DIVISOR_W-1:0];
    quo_d  = {in_quo[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= divisor;
      cnt_q  <= CNT_BITS'(DIVIDEND_W - 1);
      done_q <= (DIVIDEND_W == 1);
    end else if (cnt_q != '0) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - CNT_BITS'(1);
      done_q <= (cnt_q == CNT_BITS'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient = quo_q[QUOT_W-1:0];
  assign done     = done_q;

endmodule

// File: rtl/glove_centroid.sv
// Per-frame glove centroid: accumulates coordinates of pixels flagged as
// glove 1 / glove 2, and at frame end divides sums by counts with one shared
// sequential divider to give relative glove positions in camera pixels.
//   clk, reset              : clock, synchronous active-high reset
//   frame_end               : one-cycle end-of-active-frame pulse
//   pix_valid, pix_x, pix_y : pixel stream
//   match1, match2          : classifier flags (both may be set)
//   rel_glove{1,2}{x,y}     : centroids, held when a glove is not found
//   glove{1,2}_found        : count >= MIN_PIXELS in last completed frame
//   coords_valid            : one-cycle pulse when results update
//   busy                    : division sequence in progress
//   overrun                 : one-cycle pulse when a frame_end was dropped
//
// state      | meaning
// IDLE       | waiting for frame_end
// DIV_G1X    | dividing glove 1 x sum by glove 1 count
// DIV_G1Y    | dividing glove 1 y sum by glove 1 count
// DIV_G2X    | dividing glove 2 x sum by glove 2 count
// DIV_G2Y    | dividing glove 2 y sum by glove 2 count
// DONE       | results published, coords_valid high
module glove_centroid
  import glove_centroid_pkg::*;
#(
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_end,
  input  logic           pix_valid,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic           match1,
  input  logic           match2,
  output logic [X_W-1:0] rel_glove1x,
  output logic [Y_W-1:0] rel_glove1y,
  output logic [X_W-1:0] rel_glove2x,
  output logic [Y_W-1:0] rel_glove2y,
  output logic           glove1_found,
  output logic           glove2_found,
  output logic           coords_valid,
  output logic           busy,
  output logic           overrun
);

  state_e state_q, state_d;
  logic   started_q, started_d;

  logic [SUM_W-1:0] sumx1_q, sumy1_q, sumx2_q, sumy2_q;
  logic [CNT_W-1:0] cnt1_q, cnt2_q;
  logic [SUM_W-1:0] s_sumx1_q, s_sumy1_q, s_sumx2_q, s_sumy2_q;
  logic [CNT_W-1:0] s_cnt1_q, s_cnt2_q;

  logic [X_W-1:0] q1x_q, q2x_q;
  logic [Y_W-1:0] q1y_q;
  logic [X_W-1:0] rel1x_q, rel2x_q;
  logic [Y_W-1:0] rel1y_q, rel2y_q;
  logic           found1_q, found2_q, coords_valid_q, overrun_q;

  logic             add1, add2, accept, div_fire;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_cnt, div_divisor;
  logic [Q_W-1:0]   div_quo;

  assign add1     = pix_valid && match1;
  assign add2     = pix_valid && match2;
  assign accept   = frame_end && (state_q == ST_IDLE);
  assign div_fire = started_q && div_done;

  // A pixel on the frame_end cycle belongs to the next frame, so the
  // accumulators reload with its contribution instead of clearing to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sumx1_q <= '0; sumy1_q <= '0; cnt1_q <= '0;
      sumx2_q <= '0; sumy2_q <= '0; cnt2_q <= '0;
    end else if (frame_end) begin
      sumx1_q <= add1 ? SUM_W'(pix_x) : '0;
      sumy1_q <= add1 ? SUM_W'(pix_y) : '0;
      cnt1_q  <= add1 ? CNT_W'(1)     : '0;
      sumx2_q <= add2 ? SUM_W'(pix_x) : '0;
      sumy2_q <= add2 ? SUM_W'(pix_y) : '0;
      cnt2_q  <= add2 ? CNT_W'(1)     : '0;
    end else begin
      if (add1) begin
        sumx1_q <= sumx1_q + SUM_W'(pix_x);
        sumy1_q <= sumy1_q + SUM_W'(pix_y);
        cnt1_q  <= cnt1_q + CNT_W'(1);
      end
      if (add2) begin
        sumx2_q <= sumx2_q + SUM_W'(pix_x);
        sumy2_q <= sumy2_q + SUM_W'(pix_y);
        cnt2_q  <= cnt2_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_sumx1_q <= '0; s_sumy1_q <= '0; s_cnt1_q <= '0;
      s_sumx2_q <= '0; s_sumy2_q <= '0; s_cnt2_q <= '0;
    end else if (accept) begin
      s_sumx1_q <= sumx1_q; s_sumy1_q <= sumy1_q; s_cnt1_q <= cnt1_q;
      s_sumx2_q <= sumx2_q; s_sumy2_q <= sumy2_q; s_cnt2_q <= cnt2_q;
    end
  end

  always_comb begin
    div_dividend = s_sumx1_q;
    div_cnt      = s_cnt1_q;
    case (state_q)
      ST_DIV_G1Y: div_dividend = s_sumy1_q;
      ST_DIV_G2X: begin
        div_dividend = s_sumx2_q;
        div_cnt      = s_cnt2_q;
      end
      ST_DIV_G2Y: begin
        div_dividend = s_sumy2_q;
        div_cnt      = s_cnt2_q;
      end
      default: ;
    endcase
    // An empty glove still runs its division so the latency never varies.
    div_divisor = (div_cnt == '0) ? CNT_W'(1) : div_cnt;
  end

  seq_divider #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W),
    .QUOT_W     (Q_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        started_d = 1'b0;
        if (accept) state_d = ST_DIV_G1X;
      end
      ST_DIV_G1X, ST_DIV_G1Y, ST_DIV_G2X, ST_DIV_G2Y: begin
        if (!started_q) begin
          div_start = 1'b1;
          started_d = 1'b1;
        end else if (div_done) begin
          started_d = 1'b0;
          case (state_q)
            ST_DIV_G1X: state_d = ST_DIV_G1Y;
            ST_DIV_G1Y: state_d = ST_DIV_G2X;
            ST_DIV_G2X: state_d = ST_DIV_G2Y;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Results are published on the edge that enters DONE, so coords_valid and
  // the new coordinates are both visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1x_q <= '0; q1y_q <= '0; q2x_q <= '0;
      rel1x_q <= '0; rel1y_q <= '0; rel2x_q <= '0; rel2y_q <= '0;
      found1_q <= 1'b0; found2_q <= 1'b0;
      coords_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      coords_valid_q <= 1'b0;
      overrun_q      <= frame_end && (state_q != ST_IDLE);
      if (div_fire) begin
        case (state_q)
          ST_DIV_G1X: q1x_q <= div_quo[X_W-1:0];
          ST_DIV_G1Y: q1y_q <= div_quo[Y_W-1:0];
          ST_DIV_G2X: q2x_q <= div_quo[X_W-1:0];
          ST_DIV_G2Y: begin
            coords_valid_q <= 1'b1;
            if (s_cnt1_q >= CNT_W'(MIN_PIXELS)) begin
              rel1x_q  <= q1x_q;
              rel1y_q  <= q1y_q;
              found1_q <= 1'b1;
            end else begin
              found1_q <= 1'b0;
            end
            if (s_cnt2_q >= CNT_W'(MIN_PIXELS)) begin
              rel2x_q  <= q2x_q;
              rel2y_q  <= div_quo[Y_W-1:0];
              found2_q <= 1'b1;
            end else begin
              found2_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rel_glove1x  = rel1x_q;
  assign rel_glove1y  = rel1y_q;
  assign rel_glove2x  = rel2x_q;
  assign rel_glove2y  = rel2y_q;
  assign glove1_found = found1_q;
  assign glove2_found = found2_q;
  assign coords_valid = coords_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
